// File: rtl/tl_scratchpad_manager.sv
// TileLink uncached manager backing a local scratchpad. It handles single-beat and
// 8-beat get/put, echoes the client xact id in the grant, and never issues probes.
module tl_scratchpad_manager #(
  parameter int unsigned BLOCKS     = 16,
  parameter int unsigned BLOCK_BASE = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        acq_ready,
  input  logic        acq_valid,
  input  logic [25:0] acq_addr_block,
  input  logic [1:0]  acq_client_xact_id,
  input  logic [2:0]  acq_addr_beat,
  input  logic        acq_is_builtin_type,
  input  logic [2:0]  acq_a_type,
  input  logic [11:0] acq_union,
  input  logic [63:0] acq_data,
  input  logic        gnt_ready,
  output logic        gnt_valid,
  output logic [2:0]  gnt_addr_beat,
  output logic [1:0]  gnt_client_xact_id,
  output logic        gnt_manager_xact_id,
  output logic        gnt_is_builtin_type,
  output logic [3:0]  gnt_g_type,
  output logic [63:0] gnt_data,
  output logic        gnt_manager_id,
  output logic        fin_ready,
  input  logic        fin_valid
);

  localparam int unsigned WORDS = BLOCKS * 8;
  localparam int unsigned AW    = $clog2(WORDS);
  localparam int unsigned BW    = AW - 3;
  localparam logic [25:0] BASE26   = 26'(BLOCK_BASE);
  localparam logic [25:0] BLOCKS26 = 26'(BLOCKS);

  typedef enum logic [1:0] {S_IDLE, S_PUTB, S_GNT_ACK, S_RD} state_e;
  typedef enum logic [1:0] {OP_GET, OP_GETB, OP_PUT, OP_PUTB} op_e;

  logic [63:0] mem [WORDS];

  state_e         state_q;
  logic [2:0]     cnt_q;
  logic [BW-1:0]  blk_q;
  logic           in_range_q;
  logic           single_q;
  logic           acq_ready_q;
  logic           gnt_valid_q;
  logic [2:0]     gnt_addr_beat_q;
  logic [1:0]     gnt_xid_q;
  logic [3:0]     gnt_g_type_q;
  logic [63:0]    gnt_data_q;
  logic           gnt_builtin_q;

  logic           acq_fire, gnt_fire;
  logic [25:0]    acq_idx;
  logic           acq_in_range;
  op_e            op;
  logic           wr_en;
  logic [AW-1:0]  wr_addr;
  logic [AW-1:0]  rd_addr;
  logic           rd_in_range;
  logic [63:0]    rd_word;
  logic           unused;

  assign acq_fire     = acq_valid & acq_ready_q;
  assign gnt_fire     = gnt_valid_q & gnt_ready;
  assign acq_idx      = acq_addr_block - BASE26;
  assign acq_in_range = acq_idx < BLOCKS26;
  assign unused       = ^{fin_valid, acq_union[11:9], acq_union[0], acq_idx[25:BW]};

  always_comb begin
    op = OP_GET;
    if (!acq_is_builtin_type) begin
      op = OP_GETB;
    end else begin
      case (acq_a_type)
        3'd1:    op = OP_GETB;
        3'd2:    op = OP_PUT;
        3'd3:    op = OP_PUTB;
        default: op = OP_GET;
      endcase
    end
  end

  // Out-of-range indices alias onto real words, so the range flag gates every access.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = '0;
    if (acq_fire) begin
      if (state_q == S_IDLE && op == OP_PUT) begin
        wr_en   = acq_in_range;
        wr_addr = {acq_idx[BW-1:0], acq_addr_beat};
      end else if (state_q == S_IDLE && op == OP_PUTB) begin
        wr_en   = acq_in_range;
        wr_addr = {acq_idx[BW-1:0], 3'd0};
      end else if (state_q == S_PUTB) begin
        wr_en   = in_range_q;
        wr_addr = {blk_q, cnt_q};
      end
    end
  end

  always_comb begin
    rd_addr     = '0;
    rd_in_range = 1'b0;
    if (state_q == S_RD) begin
      rd_addr     = {blk_q, gnt_addr_beat_q + 3'd1};
      rd_in_range = in_range_q;
    end else begin
      rd_addr     = {acq_idx[BW-1:0], (op == OP_GETB) ? 3'd0 : acq_addr_beat};
      rd_in_range = acq_in_range;
    end
    rd_word = rd_in_range ? mem[rd_addr] : '0;
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int unsigned i = 0; i < 8; i++) begin
        if (acq_union[1+i]) mem[wr_addr][8*i +: 8] <= acq_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= S_IDLE;
      cnt_q           <= '0;
      blk_q           <= '0;
      in_range_q      <= 1'b0;
      single_q        <= 1'b0;
      acq_ready_q     <= 1'b0;
      gnt_valid_q     <= 1'b0;
      gnt_addr_beat_q <= '0;
      gnt_xid_q       <= '0;
      gnt_g_type_q    <= '0;
      gnt_data_q      <= '0;
      gnt_builtin_q   <= 1'b0;
    end else begin
      gnt_builtin_q <= 1'b1;
      case (state_q)
        S_IDLE: begin
          acq_ready_q <= 1'b1;
          if (acq_fire) begin
            gnt_xid_q  <= acq_client_xact_id;
            blk_q      <= acq_idx[BW-1:0];
            in_range_q <= acq_in_range;
            case (op)
              OP_GET, OP_GETB: begin
                state_q         <= S_RD;
                acq_ready_q     <= 1'b0;
                gnt_valid_q     <= 1'b1;
                single_q        <= (op == OP_GET);
                gnt_g_type_q    <= (op == OP_GET) ? 4'd3 : 4'd4;
                gnt_addr_beat_q <= (op == OP_GET) ? acq_addr_beat : 3'd0;
                gnt_data_q      <= rd_word;
              end
              OP_PUT: begin
                state_q         <= S_GNT_ACK;
                acq_ready_q     <= 1'b0;
                gnt_valid_q     <= 1'b1;
                gnt_g_type_q    <= 4'd2;
                gnt_addr_beat_q <= '0;
                gnt_data_q      <= '0;
              end
              default: begin
                state_q <= S_PUTB;
                cnt_q   <= 3'd1;
              end
            endcase
          end
        end
        S_PUTB: begin
          if (acq_fire) begin
            if (cnt_q == 3'd7) begin
              state_q         <= S_GNT_ACK;
              acq_ready_q     <= 1'b0;
              gnt_valid_q     <= 1'b1;
              gnt_g_type_q    <= 4'd2;
              gnt_addr_beat_q <= '0;
              gnt_data_q      <= '0;
              cnt_q           <= '0;
            end else begin
              cnt_q <= cnt_q + 3'd1;
            end
          end
        end
        S_GNT_ACK: begin
          if (gnt_fire) begin
            state_q      <= S_IDLE;
            acq_ready_q  <= 1'b1;
            gnt_valid_q  <= 1'b0;
            gnt_g_type_q <= '0;
          end
        end
        S_RD: begin
          if (gnt_fire) begin
            if (single_q || gnt_addr_beat_q == 3'd7) begin
              state_q         <= S_IDLE;
              acq_ready_q     <= 1'b1;
              gnt_valid_q     <= 1'b0;
              gnt_g_type_q    <= '0;
              gnt_addr_beat_q <= '0;
              gnt_data_q      <= '0;
            end else begin
              gnt_addr_beat_q <= gnt_addr_beat_q + 3'd1;
              gnt_data_q      <= rd_word;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign acq_ready           = acq_ready_q;
  assign gnt_valid           = gnt_valid_q;
  assign gnt_addr_beat       = gnt_addr_beat_q;
  assign gnt_client_xact_id  = gnt_xid_q;
  assign gnt_manager_xact_id = 1'b0;
  assign gnt_is_builtin_type = gnt_builtin_q;
  assign gnt_g_type          = gnt_g_type_q;
  assign gnt_data            = gnt_data_q;
  assign gnt_manager_id      = 1'b0;
  assign fin_ready           = 1'b1;

endmodule

// File: tb/tb_tl_scratchpad_manager.sv
// Directed bench for tl_scratchpad_manager: put/get, block transfers, stalls, masks,
// out-of-range accesses and reset during a read burst.
module tb_tl_scratchpad_manager;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        acq_ready, acq_valid;
  logic [25:0] acq_addr_block;
  logic [1:0]  acq_client_xact_id;
  logic [2:0]  acq_addr_beat;
  logic        acq_is_builtin_type;
  logic [2:0]  acq_a_type;
  logic [11:0] acq_union;
  logic [63:0] acq_data;
  logic        gnt_ready, gnt_valid;
  logic [2:0]  gnt_addr_beat;
  logic [1:0]  gnt_client_xact_id;
  logic        gnt_manager_xact_id, gnt_is_builtin_type;
  logic [3:0]  gnt_g_type;
  logic [63:0] gnt_data;
  logic        gnt_manager_id, fin_ready, fin_valid;

  int total = 0;
  int bad   = 0;

  tl_scratchpad_manager #(.BLOCKS(16), .BLOCK_BASE(0)) dut (
    .clk(clk), .reset_n(reset_n),
    .acq_ready(acq_ready), .acq_valid(acq_valid), .acq_addr_block(acq_addr_block),
    .acq_client_xact_id(acq_client_xact_id), .acq_addr_beat(acq_addr_beat),
    .acq_is_builtin_type(acq_is_builtin_type), .acq_a_type(acq_a_type),
    .acq_union(acq_union), .acq_data(acq_data),
    .gnt_ready(gnt_ready), .gnt_valid(gnt_valid), .gnt_addr_beat(gnt_addr_beat),
    .gnt_client_xact_id(gnt_client_xact_id), .gnt_manager_xact_id(gnt_manager_xact_id),
    .gnt_is_builtin_type(gnt_is_builtin_type), .gnt_g_type(gnt_g_type),
    .gnt_data(gnt_data), .gnt_manager_id(gnt_manager_id),
    .fin_ready(fin_ready), .fin_valid(fin_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [25:0] blk, input logic [1:0] xid, input logic [2:0] beat,
                      input logic [2:0] at, input logic [7:0] mask, input logic [63:0] d);
    int n = 0;
    @(negedge clk);
    acq_valid           = 1'b1;
    acq_addr_block      = blk;
    acq_client_xact_id  = xid;
    acq_addr_beat       = beat;
    acq_is_builtin_type = 1'b1;
    acq_a_type          = at;
    acq_union           = {3'b000, mask, 1'b0};
    acq_data            = d;
    while (!acq_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!acq_ready) chk("acq_timeout", {63'd0, acq_ready}, 64'd1);
    @(posedge clk);
    #1 acq_valid = 1'b0;
  endtask

  task automatic recv(input string tag, input logic [2:0] beat, input logic [3:0] gt,
                      input logic [63:0] d, input logic [1:0] xid);
    int n = 0;
    gnt_ready = 1'b1;
    @(negedge clk);
    while (!gnt_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, {63'd0, gnt_valid}, 64'd1);
    chk({tag, "_beat"}, {61'd0, gnt_addr_beat}, {61'd0, beat});
    chk({tag, "_gtype"}, {60'd0, gnt_g_type}, {60'd0, gt});
    chk({tag, "_data"}, gnt_data, d);
    chk({tag, "_xid"}, {62'd0, gnt_client_xact_id}, {62'd0, xid});
    chk({tag, "_builtin"}, {63'd0, gnt_is_builtin_type}, 64'd1);
    @(posedge clk);
    #1 gnt_ready = 1'b0;
  endtask

  initial begin
    int e;
    reset_n = 1'b0;
    acq_valid = 1'b0; acq_addr_block = '0; acq_client_xact_id = '0; acq_addr_beat = '0;
    acq_is_builtin_type = 1'b1; acq_a_type = '0; acq_union = '0; acq_data = '0;
    gnt_ready = 1'b0; fin_valid = 1'b0;

    #2;
    chk("rst_acq_ready", {63'd0, acq_ready}, 64'd0);
    chk("rst_gnt_valid", {63'd0, gnt_valid}, 64'd0);
    chk("rst_gnt_data", gnt_data, 64'd0);
    chk("rst_gnt_gtype", {60'd0, gnt_g_type}, 64'd0);
    chk("rst_gnt_xid", {62'd0, gnt_client_xact_id}, 64'd0);
    chk("fin_ready", {63'd0, fin_ready}, 64'd1);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    fin_valid = 1'b1;
    @(negedge clk);
    chk("post_rst_acq_ready", {63'd0, acq_ready}, 64'd1);

    // single-beat put then get
    send(26'd3, 2'd2, 3'd5, 3'd2, 8'hFF, 64'h1122334455667788);
    recv("put_ack", 3'd0, 4'd2, 64'd0, 2'd2);
    send(26'd3, 2'd1, 3'd5, 3'd0, 8'h00, 64'd0);
    recv("get1", 3'd5, 4'd3, 64'h1122334455667788, 2'd1);

    // putBlock block 0, beat k = 0x100+k; acq_addr_beat deliberately wrong
    for (int k = 0; k < 8; k++)
      send(26'd0, 2'd3, 3'd7, 3'd3, 8'hFF, 64'h100 + 64'(k));
    recv("putb_ack", 3'd0, 4'd2, 64'd0, 2'd3);

    // getBlock with gnt_ready held high: one beat per cycle, latency 1
    gnt_ready = 1'b1;
    send(26'd0, 2'd0, 3'd0, 3'd1, 8'h00, 64'd0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("getb_valid", {63'd0, gnt_valid}, 64'd1);
      chk("getb_beat", {61'd0, gnt_addr_beat}, 64'(k));
      chk("getb_data", gnt_data, 64'h100 + 64'(k));
      chk("getb_gtype", {60'd0, gnt_g_type}, 64'd4);
    end
    @(negedge clk);
    chk("getb_done_valid", {63'd0, gnt_valid}, 64'd0);
    chk("getb_done_ready", {63'd0, acq_ready}, 64'd1);
    gnt_ready = 1'b0;

    // getBlock with gnt_ready toggling: stalled beats stay stable
    send(26'd0, 2'd1, 3'd0, 3'd1, 8'h00, 64'd0);
    e = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      chk("tog_valid", {63'd0, gnt_valid}, 64'd1);
      chk("tog_beat", {61'd0, gnt_addr_beat}, 64'(e));
      chk("tog_data", gnt_data, 64'h100 + 64'(e));
      chk("tog_xid", {62'd0, gnt_client_xact_id}, 64'd1);
      gnt_ready = c[0];
      if (gnt_ready) e++;
    end
    @(negedge clk);
    chk("tog_done_valid", {63'd0, gnt_valid}, 64'd0);
    gnt_ready = 1'b0;

    // partial byte mask, then zero mask
    send(26'd5, 2'd0, 3'd2, 3'd2, 8'hFF, 64'd0);
    recv("clr_ack", 3'd0, 4'd2, 64'd0, 2'd0);
    send(26'd5, 2'd0, 3'd2, 3'd2, 8'h0F, 64'hFFFF_FFFF_FFFF_FFFF);
    recv("mask_ack", 3'd0, 4'd2, 64'd0, 2'd0);
    send(26'd5, 2'd3, 3'd2, 3'd0, 8'h00, 64'd0);
    recv("mask_get", 3'd2, 4'd3, 64'h0000_0000_FFFF_FFFF, 2'd3);
    send(26'd5, 2'd0, 3'd2, 3'd2, 8'h00, 64'hAAAA_AAAA_AAAA_AAAA);
    recv("mask0_ack", 3'd0, 4'd2, 64'd0, 2'd0);
    send(26'd5, 2'd0, 3'd2, 3'd0, 8'h00, 64'd0);
    recv("mask0_get", 3'd2, 4'd3, 64'h0000_0000_FFFF_FFFF, 2'd0);

    // out of range: block 16 aliases block 0 in the index bits
    send(26'd16, 2'd2, 3'd5, 3'd0, 8'h00, 64'd0);
    recv("oor_get", 3'd5, 4'd3, 64'd0, 2'd2);
    send(26'd16, 2'd2, 3'd5, 3'd2, 8'hFF, 64'hDEAD_BEEF_DEAD_BEEF);
    recv("oor_put_ack", 3'd0, 4'd2, 64'd0, 2'd2);
    send(26'd0, 2'd1, 3'd5, 3'd0, 8'h00, 64'd0);
    recv("oor_alias", 3'd5, 4'd3, 64'h105, 2'd1);
    send(26'd16, 2'd1, 3'd5, 3'd0, 8'h00, 64'd0);
    recv("oor_get2", 3'd5, 4'd3, 64'd0, 2'd1);

    // unknown a_type behaves as get
    send(26'd3, 2'd2, 3'd5, 3'd6, 8'h00, 64'd0);
    recv("atype6", 3'd5, 4'd3, 64'h1122334455667788, 2'd2);

    // reset during RD beat 3
    gnt_ready = 1'b1;
    send(26'd0, 2'd0, 3'd0, 3'd1, 8'h00, 64'd0);
    for (int k = 0; k < 3; k++) @(negedge clk);
    @(negedge clk);
    chk("rstrd_beat3", {61'd0, gnt_addr_beat}, 64'd3);
    gnt_ready = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("rstrd_valid", {63'd0, gnt_valid}, 64'd0);
    chk("rstrd_acq_ready", {63'd0, acq_ready}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rstrd_idle_ready", {63'd0, acq_ready}, 64'd1);
    chk("rstrd_idle_valid", {63'd0, gnt_valid}, 64'd0);
    send(26'd3, 2'd1, 3'd5, 3'd0, 8'h00, 64'd0);
    recv("rstrd_keep3", 3'd5, 4'd3, 64'h1122334455667788, 2'd1);
    send(26'd0, 2'd2, 3'd7, 3'd0, 8'h00, 64'd0);
    recv("rstrd_keep0", 3'd7, 4'd3, 64'h107, 2'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
